// File: rtl/decoder_stage_controller_if.sv
// Round/stage bus between the host, the union-find PE array and the stage controller.
// The master modport is the controller side; the slave modport is the host/PE side.
interface decoder_stage_controller_if #(
  parameter int STAGE_WIDTH = 3,
  parameter int CYCLE_WIDTH = 16
);
  logic                   start;
  logic                   start_ready;
  logic [STAGE_WIDTH-1:0] global_stage;
  logic                   any_busy;
  logic                   any_odd;
  logic                   result_valid;
  logic                   result_ack;
  logic [4:0]             grow_iterations;
  logic [CYCLE_WIDTH-1:0] round_cycles;
  logic                   grow_overflow;
  logic                   phase_timeout;

  modport master (
    input  start, any_busy, any_odd, result_ack,
    output start_ready, global_stage, result_valid,
           grow_iterations, round_cycles, grow_overflow, phase_timeout
  );

  modport slave (
    output start, any_busy, any_odd, result_ack,
    input  start_ready, global_stage, result_valid,
           grow_iterations, round_cycles, grow_overflow, phase_timeout
  );
endinterface

// File: rtl/decoder_stage_controller.sv
// Global stage sequencer for the union-find PE array: load, grow/merge until no odd
// cluster remains, peel, then hold the result until the host acknowledges it.
module decoder_stage_controller #(
  parameter int STAGE_WIDTH      = 3,
  parameter int MAX_GROW         = 31,
  parameter int SETTLE_CYCLES    = 2,
  parameter int QUIET_CYCLES     = 2,
  parameter int MAX_PHASE_CYCLES = 1023,
  parameter int CYCLE_WIDTH      = 16
) (
  input logic                         clk,
  input logic                         reset,
  decoder_stage_controller_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_GROW   = 3'd2,
    S_MERGE  = 3'd3,
    S_PEEL   = 3'd4,
    S_RESULT = 3'd5
  } state_t;

  localparam int PW = $clog2(MAX_PHASE_CYCLES + 1);
  localparam int QW = $clog2(QUIET_CYCLES + 1);

  localparam logic [PW-1:0] LP_SETTLE     = PW'(SETTLE_CYCLES);
  localparam logic [PW-1:0] LP_PHASE_LAST = PW'(MAX_PHASE_CYCLES - 1);
  localparam logic [QW-1:0] LP_QUIET_LAST = QW'(QUIET_CYCLES - 1);
  localparam logic [4:0]    LP_MAX_GROW   = 5'(MAX_GROW);

  state_t                 r_state;
  logic [PW-1:0]          r_phase_cnt;
  logic [QW-1:0]          r_quiet_cnt;
  logic [4:0]             r_grow_iter;
  logic [CYCLE_WIDTH-1:0] r_round_cycles;
  logic                   r_grow_overflow;
  logic                   r_phase_timeout;

  state_t w_state_next;
  logic   w_start_accept;
  logic   w_set_overflow;
  logic   w_set_timeout;
  logic   w_in_phase;
  logic   w_settled;
  logic   w_quiet_done;
  logic   w_phase_last;

  assign w_in_phase   = (r_state == S_MERGE) || (r_state == S_PEEL);
  assign w_settled    = (r_phase_cnt >= LP_SETTLE);
  // The final quiet sample completes the streak, so the exit fires on that same edge.
  assign w_quiet_done = w_in_phase && w_settled && !bus.any_busy &&
                        (r_quiet_cnt == LP_QUIET_LAST);
  assign w_phase_last = w_in_phase && (r_phase_cnt == LP_PHASE_LAST);

  // NOTE: every comb output gets a default before the case, so no path leaves a latch.
  always_comb begin
    w_state_next   = r_state;
    w_start_accept = 1'b0;
    w_set_overflow = 1'b0;
    w_set_timeout  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_start_accept = 1'b1;
          w_state_next   = S_LOAD;
        end
      end
      S_LOAD: w_state_next = S_GROW;
      S_GROW: w_state_next = S_MERGE;
      S_MERGE: begin
        if (w_quiet_done) begin
          if (bus.any_odd && (r_grow_iter < LP_MAX_GROW)) begin
            w_state_next = S_GROW;
          end else begin
            w_state_next   = S_PEEL;
            w_set_overflow = bus.any_odd;
          end
        end else if (w_phase_last) begin
          w_state_next  = S_PEEL;
          w_set_timeout = 1'b1;
        end
      end
      S_PEEL: begin
        if (w_quiet_done) begin
          w_state_next = S_RESULT;
        end else if (w_phase_last) begin
          w_state_next  = S_RESULT;
          w_set_timeout = 1'b1;
        end
      end
      S_RESULT: begin
        if (bus.result_ack) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_phase_cnt     <= '0;
      r_quiet_cnt     <= '0;
      r_grow_iter     <= '0;
      r_round_cycles  <= '0;
      r_grow_overflow <= 1'b0;
      r_phase_timeout <= 1'b0;
    end else begin
      if (w_state_next != r_state) begin
        r_phase_cnt <= '0;
        r_quiet_cnt <= '0;
      end else if (w_in_phase) begin
        r_phase_cnt <= r_phase_cnt + 1'b1;
        if (bus.any_busy)   r_quiet_cnt <= '0;
        else if (w_settled) r_quiet_cnt <= r_quiet_cnt + 1'b1;
      end

      if (w_start_accept) begin
        r_grow_iter     <= '0;
        r_round_cycles  <= '0;
        r_grow_overflow <= 1'b0;
        r_phase_timeout <= 1'b0;
      end else begin
        if ((r_state == S_GROW) && (r_grow_iter != LP_MAX_GROW))
          r_grow_iter <= r_grow_iter + 1'b1;
        if ((r_state != S_IDLE) && (r_state != S_RESULT) && (r_round_cycles != '1))
          r_round_cycles <= r_round_cycles + 1'b1;
        if (w_set_overflow) r_grow_overflow <= 1'b1;
        if (w_set_timeout)  r_phase_timeout <= 1'b1;
      end
    end
  end

  assign bus.global_stage    = STAGE_WIDTH'(r_state);
  assign bus.start_ready     = (r_state == S_IDLE);
  assign bus.result_valid    = (r_state == S_RESULT);
  assign bus.grow_iterations = r_grow_iter;
  assign bus.round_cycles    = r_round_cycles;
  assign bus.grow_overflow   = r_grow_overflow;
  assign bus.phase_timeout   = r_phase_timeout;

endmodule

// File: tb/tb_decoder_stage_controller.sv
// Directed bench for decoder_stage_controller: stage sequences per cycle, round statistics,
// overflow/timeout flags, mid-round reset and the ack/start collision in RESULT_VALID.
module tb_decoder_stage_controller;

  logic clk = 1'b0;
  logic reset;
  int   n_total = 0;
  int   n_bad   = 0;

  always #5 clk = ~clk;

  decoder_stage_controller_if #(.STAGE_WIDTH(3), .CYCLE_WIDTH(16)) bus ();

  decoder_stage_controller #(
    .STAGE_WIDTH(3), .MAX_GROW(3), .SETTLE_CYCLES(2), .QUIET_CYCLES(2),
    .MAX_PHASE_CYCLES(20), .CYCLE_WIDTH(16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic string rep(input string c, input int n);
    string s = "";
    for (int k = 0; k < n; k++) s = {s, c};
    return s;
  endfunction

  // One character per cycle after start acceptance: expected stage, any_busy, any_odd.
  task automatic run_vec(input string tag, input string stg, input string bsy, input string odd);
    bus.start = 1'b1;
    for (int i = 0; i < stg.len(); i++) begin
      tick();
      bus.start = 1'b0;
      if (i == 0) begin
        check({tag, "_clr_grow"},  int'(bus.grow_iterations), 0);
        check({tag, "_clr_cyc"},   int'(bus.round_cycles), 0);
        check({tag, "_clr_ovf"},   int'(bus.grow_overflow), 0);
        check({tag, "_clr_tmo"},   int'(bus.phase_timeout), 0);
      end
      check($sformatf("%s_stage%0d", tag, i), int'(bus.global_stage), int'(stg[i]) - 48);
      bus.any_busy = (int'(bsy[i]) == 49);
      bus.any_odd  = (int'(odd[i]) == 49);
    end
    bus.any_busy = 1'b0;
    bus.any_odd  = 1'b0;
  endtask

  task automatic finish_round(input string tag, input int grow, input int cyc,
                              input int ovf, input int tmo, input bit with_start);
    check({tag, "_valid"}, int'(bus.result_valid), 1);
    check({tag, "_ready"}, int'(bus.start_ready), 0);
    check({tag, "_grow"},  int'(bus.grow_iterations), grow);
    check({tag, "_cyc"},   int'(bus.round_cycles), cyc);
    check({tag, "_ovf"},   int'(bus.grow_overflow), ovf);
    check({tag, "_tmo"},   int'(bus.phase_timeout), tmo);
    tick();
    tick();
    check({tag, "_hold_stage"}, int'(bus.global_stage), 5);
    check({tag, "_hold_valid"}, int'(bus.result_valid), 1);
    check({tag, "_hold_cyc"},   int'(bus.round_cycles), cyc);
    bus.result_ack = 1'b1;
    bus.start      = with_start;
    tick();
    bus.result_ack = 1'b0;
    bus.start      = 1'b0;
    check({tag, "_ack_stage"}, int'(bus.global_stage), 0);
    check({tag, "_ack_ready"}, int'(bus.start_ready), 1);
    check({tag, "_ack_valid"}, int'(bus.result_valid), 0);
    if (with_start) begin
      tick();
      check({tag, "_no_restart"}, int'(bus.global_stage), 0);
    end
  endtask

  initial begin
    reset          = 1'b1;
    bus.start      = 1'b0;
    bus.any_busy   = 1'b0;
    bus.any_odd    = 1'b0;
    bus.result_ack = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    check("rst_stage", int'(bus.global_stage), 0);
    check("rst_ready", int'(bus.start_ready), 1);
    check("rst_valid", int'(bus.result_valid), 0);
    check("rst_grow",  int'(bus.grow_iterations), 0);
    check("rst_cyc",   int'(bus.round_cycles), 0);
    check("rst_ovf",   int'(bus.grow_overflow), 0);
    check("rst_tmo",   int'(bus.phase_timeout), 0);
    tick();
    check("idle_stay", int'(bus.global_stage), 0);

    run_vec("nodef", "12333344445", rep("0", 11), rep("0", 11));
    finish_round("nodef", 1, 10, 0, 0, 1'b0);

    run_vec("twogrow", "123333323333344445", "001110001110000000", "001111100000000000");
    finish_round("twogrow", 2, 17, 0, 0, 1'b0);

    run_vec("glitch", "1233333344445", "0000010000000", rep("0", 13));
    finish_round("glitch", 1, 12, 0, 0, 1'b0);

    run_vec("ovf", "123333233332333344445", rep("0", 21), rep("1", 21));
    finish_round("ovf", 3, 20, 1, 0, 1'b0);

    run_vec("tmo", {"12", rep("3", 20), rep("4", 20), "5"}, rep("1", 43), rep("0", 43));
    finish_round("tmo", 1, 42, 0, 1, 1'b1);

    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    bus.any_busy = 1'b1;
    tick();
    tick();
    tick();
    check("rstmid_pre_stage", int'(bus.global_stage), 3);
    check("rstmid_pre_grow",  int'(bus.grow_iterations), 1);
    reset = 1'b1;
    tick();
    reset        = 1'b0;
    bus.any_busy = 1'b0;
    check("rstmid_stage", int'(bus.global_stage), 0);
    check("rstmid_ready", int'(bus.start_ready), 1);
    check("rstmid_grow",  int'(bus.grow_iterations), 0);
    check("rstmid_cyc",   int'(bus.round_cycles), 0);

    run_vec("again", "12333344445", rep("0", 11), rep("0", 11));
    finish_round("again", 1, 10, 0, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
